// File: rtl/mfsk_pkg.sv
// Shared types and elaboration helpers for the M-ary FSK frame transmitter.
package mfsk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_PRE  = 2'd2,
        ST_PAY  = 2'd3
    } state_e;

    localparam int unsigned CRC_MAX_W = 32;

    // Counter width able to hold 0..n-1 (never narrower than one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned num_tones(input int unsigned bps);
        return 1 << bps;
    endfunction

    function automatic int unsigned num_syms(input int unsigned data_w, input int unsigned crc_w,
                                             input int unsigned bps);
        return (data_w + crc_w) / bps;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // One MSB-first CRC step; only the low w bits of the result are meaningful.
    function automatic logic [CRC_MAX_W-1:0] crc_step(input logic [CRC_MAX_W-1:0] crc,
                                                      input logic din,
                                                      input logic [CRC_MAX_W-1:0] poly,
                                                      input int unsigned w);
        logic                 fb;
        logic [CRC_MAX_W-1:0] nxt;
        logic [CRC_MAX_W-1:0] mask;
        fb   = crc[5'(w - 1)] ^ din;
        nxt  = {crc[CRC_MAX_W-2:0], 1'b0} ^ (fb ? poly : '0);
        mask = (w >= CRC_MAX_W) ? '1 : ((32'd1 << w) - 32'd1);
        return nxt & mask;
    endfunction

endpackage

// File: rtl/mfsk_frame_tx_nco.sv
// Tone mapping and continuous-phase accumulator feeding the downstream sine modulator.
module mfsk_phase_nco #(
    parameter int unsigned BPS       = 2,
    parameter int unsigned PHASE_W   = 8,
    parameter int unsigned FREQ_BASE = 1,
    parameter int unsigned FREQ_STEP = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic [BPS-1:0]     sym_i,
    output logic [PHASE_W-1:0] freq_word_o,
    output logic [PHASE_W-1:0] phase_o
);

    logic               en_q;
    logic [PHASE_W-1:0] freq_q, freq_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    int unsigned        incr_c;

    // en_i/sym_i are next-cycle values, so freq_q lines up with the registered symbol.
    always_comb begin
        incr_c  = FREQ_BASE + 32'(sym_i) * FREQ_STEP;
        freq_d  = en_i ? PHASE_W'(incr_c) : '0;
        phase_d = phase_q;
        if (clr_i) begin
            phase_d = '0;
        end else if (en_q) begin
            phase_d = phase_q + freq_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q    <= 1'b0;
            freq_q  <= '0;
            phase_q <= '0;
        end else begin
            en_q    <= en_i;
            freq_q  <= freq_d;
            phase_q <= phase_d;
        end
    end

    assign freq_word_o = freq_q;
    assign phase_o     = phase_q;

endmodule

// File: rtl/mfsk_frame_tx.sv
// Frame transmitter: latch word, bit-serial CRC, then preamble and {data,crc} as M-ary symbols.
module mfsk_frame_tx
    import mfsk_pkg::*;
#(
    parameter int unsigned     DATA_W        = 8,
    parameter int unsigned     CRC_W         = 8,
    parameter logic [CRC_W-1:0] CRC_POLY     = CRC_W'(8'h07),
    parameter logic [CRC_W-1:0] CRC_INIT     = '0,
    parameter int unsigned     BPS           = 2,
    parameter int unsigned     SPS           = 16,
    parameter int unsigned     PREAMBLE_SYMS = 4,
    parameter int unsigned     PHASE_W       = 8,
    parameter int unsigned     FREQ_BASE     = 1,
    parameter int unsigned     FREQ_STEP     = 1
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [BPS-1:0]     sym,
    output logic               sym_valid,
    output logic               sym_start,
    output logic [PHASE_W-1:0] freq_word,
    output logic [PHASE_W-1:0] phase,
    output logic               busy,
    output logic               frame_done
);

    localparam int unsigned FRAME_W = DATA_W + CRC_W;
    localparam int unsigned M       = num_tones(BPS);
    localparam int unsigned NSYM    = num_syms(DATA_W, CRC_W, BPS);
    localparam int unsigned SYM_MAX = max_u(PREAMBLE_SYMS, NSYM);
    localparam int unsigned SAMP_W  = cnt_w(SPS);
    localparam int unsigned SYM_W   = cnt_w(SYM_MAX);
    localparam int unsigned BIT_W   = cnt_w(DATA_W);

    if ((FRAME_W % BPS) != 0) begin : g_bps_check
        $error("mfsk_frame_tx: DATA_W+CRC_W must be a multiple of BPS");
    end
    if (SPS < 2) begin : g_sps_check
        $error("mfsk_frame_tx: SPS must be at least 2");
    end
    if (CRC_W > CRC_MAX_W) begin : g_crc_check
        $error("mfsk_frame_tx: CRC_W too wide");
    end

    state_e              state_q, state_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [SAMP_W-1:0]   samp_cnt_q, samp_cnt_d;
    logic [SYM_W-1:0]    sym_cnt_q, sym_cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CRC_W-1:0]    crc_q, crc_d;
    logic [FRAME_W-1:0]  shreg_q, shreg_d;
    logic                in_ready_q, in_ready_d;
    logic [BPS-1:0]      sym_q, sym_d;
    logic                sym_valid_q, sym_valid_d;
    logic                sym_start_q, sym_start_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic                phase_clr_c;
    logic [CRC_W-1:0]    crc_nxt_c;
    logic [FRAME_W-1:0]  frame_c;
    logic                last_samp_c;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        samp_cnt_d   = samp_cnt_q;
        sym_cnt_d    = sym_cnt_q;
        data_d       = data_q;
        crc_d        = crc_q;
        shreg_d      = shreg_q;
        in_ready_d   = in_ready_q;
        sym_d        = sym_q;
        sym_valid_d  = sym_valid_q;
        sym_start_d  = 1'b0;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        phase_clr_c  = 1'b0;
        crc_nxt_c    = CRC_W'(crc_step(32'(crc_q), data_q[bit_cnt_q], 32'(CRC_POLY), CRC_W));
        frame_c      = {data_q, crc_nxt_c};
        last_samp_c  = (samp_cnt_q == SAMP_W'(SPS - 1));

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d    = ST_CALC;
                    data_d     = in_data;
                    crc_d      = CRC_INIT;
                    bit_cnt_d  = BIT_W'(DATA_W - 1);
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end

            ST_CALC: begin
                crc_d     = crc_nxt_c;
                bit_cnt_d = bit_cnt_q - BIT_W'(1);
                // Last data bit: frame_c already holds the final CRC, go on air next cycle.
                if (bit_cnt_q == '0) begin
                    samp_cnt_d  = '0;
                    sym_cnt_d   = '0;
                    sym_valid_d = 1'b1;
                    sym_start_d = 1'b1;
                    phase_clr_c = 1'b1;
                    if (PREAMBLE_SYMS != 0) begin
                        state_d = ST_PRE;
                        sym_d   = '0;
                        shreg_d = frame_c;
                    end else begin
                        state_d = ST_PAY;
                        sym_d   = frame_c[FRAME_W-1 -: BPS];
                        shreg_d = frame_c << BPS;
                    end
                end
            end

            ST_PRE: begin
                samp_cnt_d = samp_cnt_q + SAMP_W'(1);
                if (last_samp_c) begin
                    samp_cnt_d  = '0;
                    sym_start_d = 1'b1;
                    sym_cnt_d   = sym_cnt_q + SYM_W'(1);
                    if (sym_cnt_q == SYM_W'(PREAMBLE_SYMS - 1)) begin
                        state_d   = ST_PAY;
                        sym_cnt_d = '0;
                        sym_d     = shreg_q[FRAME_W-1 -: BPS];
                        shreg_d   = shreg_q << BPS;
                    end else begin
                        sym_d = (sym_q == '0) ? BPS'(M - 1) : '0;
                    end
                end
            end

            ST_PAY: begin
                samp_cnt_d = samp_cnt_q + SAMP_W'(1);
                if ((sym_cnt_q == SYM_W'(NSYM - 1)) && (samp_cnt_q == SAMP_W'(SPS - 2))) begin
                    frame_done_d = 1'b1;
                end
                if (last_samp_c) begin
                    samp_cnt_d  = '0;
                    sym_start_d = 1'b1;
                    sym_cnt_d   = sym_cnt_q + SYM_W'(1);
                    if (sym_cnt_q == SYM_W'(NSYM - 1)) begin
                        state_d     = ST_IDLE;
                        sym_cnt_d   = '0;
                        sym_d       = '0;
                        sym_valid_d = 1'b0;
                        sym_start_d = 1'b0;
                        busy_d      = 1'b0;
                        in_ready_d  = 1'b1;
                        phase_clr_c = 1'b1;
                    end else begin
                        sym_d   = shreg_q[FRAME_W-1 -: BPS];
                        shreg_d = shreg_q << BPS;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            samp_cnt_q   <= '0;
            sym_cnt_q    <= '0;
            data_q       <= '0;
            crc_q        <= '0;
            shreg_q      <= '0;
            in_ready_q   <= 1'b1;
            sym_q        <= '0;
            sym_valid_q  <= 1'b0;
            sym_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            sym_cnt_q    <= sym_cnt_d;
            data_q       <= data_d;
            crc_q        <= crc_d;
            shreg_q      <= shreg_d;
            in_ready_q   <= in_ready_d;
            sym_q        <= sym_d;
            sym_valid_q  <= sym_valid_d;
            sym_start_q  <= sym_start_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    mfsk_phase_nco #(
        .BPS       (BPS),
        .PHASE_W   (PHASE_W),
        .FREQ_BASE (FREQ_BASE),
        .FREQ_STEP (FREQ_STEP)
    ) u_nco (
        .clk         (sys_clk),
        .rst_n       (rst_n),
        .en_i        (sym_valid_d),
        .clr_i       (phase_clr_c),
        .sym_i       (sym_d),
        .freq_word_o (freq_word),
        .phase_o     (phase)
    );

    assign in_ready   = in_ready_q;
    assign sym        = sym_q;
    assign sym_valid  = sym_valid_q;
    assign sym_start  = sym_start_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mfsk_frame_tx.sv
// Scoreboard bench: accepts push hand-computed symbol/timing expectations, monitors pop and compare.
module tb_mfsk_frame_tx;

    localparam int L0 = 8 + 12 * 16;
    localparam int L1 = 8 + 16 * 4;
    localparam int L2 = 8 + 8 * 2;

    typedef struct {
        logic [1:0] s;
        logic [3:0] f;
        int         at;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] d0, d1, d2;
    logic       v0, v1, v2;

    logic       r0, sv0, ss0, busy0, fd0;
    logic [1:0] sym0;
    logic [7:0] fw0, ph0o;
    logic       r1, sv1, ss1, busy1, fd1;
    logic [0:0] sym1;
    logic [7:0] fw1, ph1o;
    logic       r2, sv2, ss2, busy2, fd2;
    logic [1:0] sym2;
    logic [3:0] fw2, ph2o;

    mfsk_frame_tx u0 (
        .sys_clk(clk), .rst_n(rst_n), .in_data(d0), .in_valid(v0), .in_ready(r0),
        .sym(sym0), .sym_valid(sv0), .sym_start(ss0), .freq_word(fw0), .phase(ph0o),
        .busy(busy0), .frame_done(fd0)
    );

    mfsk_frame_tx #(.BPS(1), .SPS(4), .PREAMBLE_SYMS(0)) u1 (
        .sys_clk(clk), .rst_n(rst_n), .in_data(d1), .in_valid(v1), .in_ready(r1),
        .sym(sym1), .sym_valid(sv1), .sym_start(ss1), .freq_word(fw1), .phase(ph1o),
        .busy(busy1), .frame_done(fd1)
    );

    mfsk_frame_tx #(.SPS(2), .PREAMBLE_SYMS(0), .PHASE_W(4), .FREQ_BASE(15), .FREQ_STEP(1)) u2 (
        .sys_clk(clk), .rst_n(rst_n), .in_data(d2), .in_valid(v2), .in_ready(r2),
        .sym(sym2), .sym_valid(sv2), .sym_start(ss2), .freq_word(fw2), .phase(ph2o),
        .busy(busy2), .frame_done(fd2)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t q0[$], q1[$], q2[$];
    int   dq0[$], dq1[$], dq2[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got event want none (t=%0t)", name, $time);
    endtask

    // Hand-computed {data, CRC-8 poly 07} words for the directed payloads.
    function automatic logic [15:0] exp_frame(input logic [7:0] d, output logic ok);
        ok = 1'b1;
        case (d)
            8'hBB:   return 16'hBB28;
            8'h00:   return 16'h0000;
            8'h01:   return 16'h0107;
            8'hFF:   return 16'hFFF3;
            default: begin ok = 1'b0; return 16'h0000; end
        endcase
    endfunction

    // (15 + s) mod 16 for the 4-bit phase instance.
    function automatic logic [3:0] f2(input logic [1:0] s);
        case (s)
            2'd0:    return 4'd15;
            2'd1:    return 4'd0;
            2'd2:    return 4'd1;
            default: return 4'd2;
        endcase
    endfunction

    // Monitor for the default instance.
    initial begin
        int         left0;
        logic [1:0] cur0;
        logic [7:0] phx;
        logic [15:0] fr;
        logic       ok;
        exp_t       e;
        left0 = 0; cur0 = '0; phx = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q0.delete(); dq0.delete(); left0 = 0; phx = '0;
            end else begin
                if (v0 && r0) begin
                    fr = exp_frame(d0, ok);
                    chk("u0_accept_known_data", 32'(ok), 32'd1);
                    for (int i = 0; i < 4; i++) begin
                        e.s = (i % 2 == 1) ? 2'd3 : 2'd0; e.f = '0; e.at = cyc + 9 + i * 16;
                        q0.push_back(e);
                    end
                    for (int i = 0; i < 8; i++) begin
                        e.s = fr[15 - 2 * i -: 2]; e.f = '0; e.at = cyc + 9 + (4 + i) * 16;
                        q0.push_back(e);
                    end
                    dq0.push_back(cyc + L0);
                end
                if (ss0) begin
                    if (q0.size() == 0) begin
                        fail("u0_sym_start_unexpected");
                    end else begin
                        e = q0.pop_front();
                        chk("u0_sym", 32'(sym0), 32'(e.s));
                        chk("u0_sym_start_cyc", 32'(cyc), 32'(e.at));
                        chk("u0_prev_sym_len", 32'(left0), 32'd0);
                        cur0  = e.s;
                        left0 = 16;
                    end
                end
                if (sv0) begin
                    if (left0 == 0) fail("u0_sym_valid_extra");
                    else left0--;
                    chk("u0_freq_word", 32'(fw0), 32'(8'd1 + 8'(cur0)));
                    chk("u0_phase", 32'(ph0o), 32'(phx));
                    phx = phx + 8'd1 + 8'(cur0);
                end else begin
                    chk("u0_idle_outputs", {8'(sym0), fw0, ph0o, 7'd0, ss0}, 32'd0);
                    chk("u0_sym_gap", 32'(left0), 32'd0);
                    left0 = 0;
                    phx   = '0;
                end
                chk("u0_ready_vs_busy", 32'(r0), 32'(!busy0));
                if (fd0) begin
                    if (dq0.size() == 0) begin
                        fail("u0_frame_done_unexpected");
                    end else begin
                        chk("u0_done_cyc", 32'(cyc), 32'(dq0.pop_front()));
                        chk("u0_done_all_syms", 32'(q0.size()), 32'd0);
                    end
                end
            end
        end
    end

    // Monitors for the BPS=1 and 4-bit-phase instances.
    initial begin
        exp_t       e;
        logic [15:0] fr;
        logic       ok;
        logic [3:0] curf;
        logic [3:0] phy;
        curf = '0; phy = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q1.delete(); dq1.delete(); q2.delete(); dq2.delete(); phy = '0;
            end else begin
                if (v1 && r1) begin
                    fr = exp_frame(d1, ok);
                    chk("u1_accept_known_data", 32'(ok), 32'd1);
                    for (int i = 0; i < 16; i++) begin
                        e.s = {1'b0, fr[15 - i]}; e.f = '0; e.at = cyc + 9 + i * 4;
                        q1.push_back(e);
                    end
                    dq1.push_back(cyc + L1);
                end
                if (ss1) begin
                    if (q1.size() == 0) begin
                        fail("u1_sym_start_unexpected");
                    end else begin
                        e = q1.pop_front();
                        chk("u1_sym", 32'(sym1), 32'(e.s));
                        chk("u1_sym_start_cyc", 32'(cyc), 32'(e.at));
                    end
                end
                if (fd1) begin
                    if (dq1.size() == 0) fail("u1_frame_done_unexpected");
                    else chk("u1_done_cyc", 32'(cyc), 32'(dq1.pop_front()));
                end
                if (v2 && r2) begin
                    fr = exp_frame(d2, ok);
                    chk("u2_accept_known_data", 32'(ok), 32'd1);
                    for (int i = 0; i < 8; i++) begin
                        e.s = fr[15 - 2 * i -: 2]; e.f = f2(e.s); e.at = cyc + 9 + i * 2;
                        q2.push_back(e);
                    end
                    dq2.push_back(cyc + L2);
                end
                if (ss2) begin
                    if (q2.size() == 0) begin
                        fail("u2_sym_start_unexpected");
                    end else begin
                        e = q2.pop_front();
                        chk("u2_sym", 32'(sym2), 32'(e.s));
                        chk("u2_sym_start_cyc", 32'(cyc), 32'(e.at));
                        curf = e.f;
                    end
                end
                if (sv2) begin
                    chk("u2_freq_word", 32'(fw2), 32'(curf));
                    chk("u2_phase", 32'(ph2o), 32'(phy));
                    phy = phy + curf;
                end else begin
                    chk("u2_idle_phase", {24'd0, fw2, ph2o}, 32'd0);
                    phy = '0;
                end
                if (fd2) begin
                    if (dq2.size() == 0) fail("u2_frame_done_unexpected");
                    else chk("u2_done_cyc", 32'(cyc), 32'(dq2.pop_front()));
                end
            end
        end
    end

    task automatic wait_ready0();
        int n = 0;
        while (!r0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!r0) fail("u0_ready_timeout");
    endtask

    task automatic send0(input logic [7:0] d);
        wait_ready0();
        v0 = 1'b1;
        d0 = d;
        @(posedge clk); #1;
        v0 = 1'b0;
        d0 = 8'h5A;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() + dq0.size() + q1.size() + dq1.size() + q2.size() + dq2.size()) != 0
               && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", 32'(q0.size() + dq0.size() + q1.size() + dq1.size() + q2.size() + dq2.size()),
            32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        d0 = '0; d1 = '0; d2 = '0;
        #12;
        chk("reset_in_ready", 32'(r0), 32'd1);
        chk("reset_outputs", {8'(sym0), fw0, ph0o, 4'd0, sv0, ss0, busy0, fd0}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        send0(8'hBB);
        drain();
        send0(8'h00);
        drain();

        // Held valid: second word must be taken exactly one idle cycle after frame_done.
        wait_ready0();
        v0 = 1'b1;
        d0 = 8'h01;
        @(posedge clk); #1;
        d0 = 8'h5A;
        n  = 0;
        while (!r0 && n < 1000) begin
            @(posedge clk); #1;
            n++;
            if (n == 150) d0 = 8'hFF;
        end
        chk("b2b_accept_gap", 32'(n), 32'(L0));
        @(posedge clk); #1;
        v0 = 1'b0;
        d0 = 8'h00;
        drain();

        // Abort in payload symbol 3, then a clean frame.
        send0(8'hBB);
        repeat (124) @(posedge clk);
        #1;
        chk("pre_abort_on_air", {30'd0, sv0, busy0}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(r0), 32'd1);
        chk("abort_outputs", {8'(sym0), fw0, ph0o, 4'd0, sv0, ss0, busy0, fd0}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (250) @(posedge clk);
        #1;
        send0(8'hBB);
        drain();

        // One-bit symbols, no preamble.
        v1 = 1'b1; d1 = 8'hBB;
        @(posedge clk); #1;
        v1 = 1'b0; d1 = 8'h5A;
        drain();

        // 4-bit phase with wrapping tone words.
        v2 = 1'b1; d2 = 8'hFF;
        @(posedge clk); #1;
        v2 = 1'b0; d2 = 8'h5A;
        drain();
        v2 = 1'b1; d2 = 8'h01;
        @(posedge clk); #1;
        v2 = 1'b0; d2 = 8'h5A;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
